// File: rtl/timekeeper_mux.sv
// timekeeper_mux: settable time-of-day counter with alarm and multiplexed 7-segment scan
module timekeeper_mux #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int NUM_DIGITS    = 6,
   parameter int SCAN_DIV      = 1
) (
   input  logic       clk_1ms,
   input  logic       reset,
   input  logic       mil_time,
   input  logic       set_valid,
   input  logic [4:0] set_hour,
   input  logic [5:0] set_min,
   input  logic [5:0] set_sec,
   output logic       set_ready,
   output logic       set_err,
   input  logic       alarm_en,
   input  logic [4:0] alarm_hour,
   input  logic [5:0] alarm_min,
   output logic       alarm_pulse,
   output logic       sec_pulse,
   output logic [4:0] hour,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       am_pm,
   output logic [7:0] segment_data,
   output logic [2:0] digit_select
);
   localparam int DW = $clog2(TICKS_PER_SEC);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICKS_PER_SEC - 1);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [2:0] DIG_LAST = 3'(NUM_DIGITS - 1);
   localparam logic [2:0] DIG_OFS = (NUM_DIGITS == 4) ? 3'd2 : 3'd0;

   logic [DW-1:0] div_q, div_d;
   logic [4:0]    hour_q, hour_d, hour_disp;
   logic [5:0]    min_q, min_d, sec_q, sec_d;
   logic          ready_q, ready_d, err_q, err_d, spulse_q, spulse_d, apulse_q, apulse_d;
   logic [SW-1:0] scan_q, scan_d;
   logic [2:0]    dig_q, dig_d, field;
   logic [7:0]    seg_q, seg_d;
   logic [3:0]    val;
   logic          accept, load_ok, load, term, tick, sec_wrap, min_wrap, scan_adv;

   function automatic logic [3:0] ones(input logic [5:0] v);
      return 4'(v % 6'd10);
   endfunction

   function automatic logic [3:0] tens(input logic [5:0] v);
      return 4'(v / 6'd10);
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Load handshake, divider and single-edge sec/min/hour carry chain; a load beats a coincident tick
   always_comb begin
      accept   = set_valid & ready_q;
      load_ok  = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
      load     = accept & load_ok;
      term     = div_q == DIV_LAST;
      tick     = term & ~accept;
      sec_wrap = sec_q == 6'd59;
      min_wrap = min_q == 6'd59;
      div_d    = (load | term) ? '0 : div_q + DW'(1);
      sec_d    = load ? set_sec : tick ? (sec_wrap ? 6'd0 : sec_q + 6'd1) : sec_q;
      min_d    = load ? set_min : (tick & sec_wrap) ? (min_wrap ? 6'd0 : min_q + 6'd1) : min_q;
      hour_d   = load ? set_hour : (tick & sec_wrap & min_wrap) ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1) : hour_q;
      ready_d  = ~accept;
      err_d    = accept & ~load_ok;
      spulse_d = tick;
      apulse_d = tick & alarm_en & (sec_d == 6'd0) & (min_d == alarm_min) & (hour_d == alarm_hour);
   end

   // 12/24 h display mapping and scan digit selection with glyph lookup for the next lit digit
   always_comb begin
      am_pm     = hour_q >= 5'd12;
      hour_disp = mil_time ? hour_q : (hour_q == 5'd0) ? 5'd12 : (hour_q > 5'd12) ? hour_q - 5'd12 : hour_q;
      scan_adv  = scan_q == SCAN_LAST;
      scan_d    = scan_adv ? '0 : scan_q + SW'(1);
      dig_d     = scan_adv ? ((dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1) : dig_q;
      field     = dig_d + DIG_OFS;
      val       = (field == 3'd0) ? ones(sec_q) :
                  (field == 3'd1) ? tens(sec_q) :
                  (field == 3'd2) ? ones(min_q) :
                  (field == 3'd3) ? tens(min_q) :
                  (field == 3'd4) ? ones({1'b0, hour_disp}) : tens({1'b0, hour_disp});
      seg_d     = ((field == 3'd5) && (val == 4'd0) && !mil_time) ? 8'h00 :
                  {(field == 3'd4) && !mil_time && am_pm, glyph(val)};
   end

   // State registers; reset clears time, handshake, pulses and scan
   always_ff @(posedge clk_1ms) begin
      if (reset) begin
         div_q    <= '0;
         hour_q   <= '0;
         min_q    <= '0;
         sec_q    <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         spulse_q <= 1'b0;
         apulse_q <= 1'b0;
         scan_q   <= '0;
         dig_q    <= '0;
         seg_q    <= 8'h00;
      end else begin
         div_q    <= div_d;
         hour_q   <= hour_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         spulse_q <= spulse_d;
         apulse_q <= apulse_d;
         scan_q   <= scan_d;
         dig_q    <= dig_d;
         seg_q    <= seg_d;
      end
   end

   assign set_ready    = ready_q;
   assign set_err      = err_q;
   assign sec_pulse    = spulse_q;
   assign alarm_pulse  = apulse_q;
   assign hour         = hour_disp;
   assign min          = min_q;
   assign sec          = sec_q;
   assign segment_data = seg_q;
   assign digit_select = dig_q;
endmodule

// File: tb/tb_timekeeper_mux.sv
// tb_timekeeper_mux: scoreboard bench comparing timekeeper_mux against a seconds-of-day reference model
module tb_timekeeper_mux;
   localparam int T = 4, N = 6, SD = 1;

   logic       clk_1ms = 1'b0, reset = 1'b1, mil_time = 1'b1, set_valid = 1'b0, alarm_en = 1'b0;
   logic [4:0] set_hour = '0, alarm_hour = '0;
   logic [5:0] set_min = '0, set_sec = '0, alarm_min = '0;
   logic       set_ready, set_err, alarm_pulse, sec_pulse, am_pm;
   logic [4:0] hour;
   logic [5:0] min, sec;
   logic [7:0] segment_data;
   logic [2:0] digit_select;

   timekeeper_mux #(.TICKS_PER_SEC(T), .NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
      .clk_1ms(clk_1ms), .reset(reset), .mil_time(mil_time), .set_valid(set_valid),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .set_ready(set_ready),
      .set_err(set_err), .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .alarm_pulse(alarm_pulse), .sec_pulse(sec_pulse), .hour(hour), .min(min), .sec(sec),
      .am_pm(am_pm), .segment_data(segment_data), .digit_select(digit_select)
   );

   always #5 clk_1ms = ~clk_1ms;

   typedef struct {
      int t;
      bit sp, ap, err, rdy;
      int dig;
      int seg;
   } exp_t;

   exp_t q[$];
   int checks = 0, failures = 0;
   int m_t = 0, m_div = 0, m_dig = 0, m_scan = 0;
   bit m_rdy = 0;
   logic [6:0] gl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int disp_hour(input int h, input bit mil);
      return mil ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
   endfunction

   function automatic int exp_seg(input int t, input bit mil, input int d);
      int h, m, s, hd, f;
      int vals[6];
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      hd = disp_hour(h, mil);
      vals = '{s % 10, s / 10, m % 10, m / 10, hd % 10, hd / 10};
      f = d + ((N == 4) ? 2 : 0);
      if (f == 5 && vals[5] == 0 && !mil) return 0;
      return {24'd0, (f == 4 && !mil && h >= 12), gl[vals[f]]};
   endfunction

   // Predict the effect of the coming edge, queue it, then let the edge happen
   task automatic cyc();
      exp_t e;
      bit acc, ok, term;
      e.sp = 0; e.ap = 0; e.err = 0;
      if (reset) begin
         m_t = 0; m_div = 0; m_rdy = 0; m_scan = 0; m_dig = 0;
         e.seg = 0;
      end else begin
         acc  = set_valid && m_rdy;
         ok   = set_hour <= 23 && set_min <= 59 && set_sec <= 59;
         term = m_div == T - 1;
         m_scan = (m_scan + 1) % SD;
         if (m_scan == 0) m_dig = (m_dig + 1) % N;
         e.seg = exp_seg(m_t, mil_time, m_dig);
         e.err = acc && !ok;
         if (acc && ok) begin
            m_t = set_hour * 3600 + set_min * 60 + set_sec;
            m_div = 0;
         end else begin
            m_div = term ? 0 : m_div + 1;
            if (term && !acc) begin
               m_t = (m_t + 1) % 86400;
               e.sp = 1;
               e.ap = alarm_en && alarm_hour < 24 && alarm_min < 60 &&
                      m_t == alarm_hour * 3600 + alarm_min * 60;
            end
         end
         m_rdy = !acc;
      end
      e.rdy = m_rdy; e.t = m_t; e.dig = m_dig;
      q.push_back(e);
      @(posedge clk_1ms);
      #1;
   endtask

   task automatic idle(input int n);
      set_valid = 0;
      repeat (n) cyc();
   endtask

   task automatic load(input int h, input int m, input int s);
      int g = 0;
      set_valid = 0;
      while (!m_rdy && g < 4) begin
         cyc();
         g++;
      end
      set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
      set_valid = 1;
      cyc();
      set_valid = 0;
   endtask

   // Monitor: compare every presented output against the oldest queued prediction
   always @(negedge clk_1ms) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("hour", int'(hour), disp_hour(e.t / 3600, mil_time));
         chk("min", int'(min), (e.t / 60) % 60);
         chk("sec", int'(sec), e.t % 60);
         chk("am_pm", int'(am_pm), int'(e.t / 3600 >= 12));
         chk("sec_pulse", int'(sec_pulse), int'(e.sp));
         chk("alarm_pulse", int'(alarm_pulse), int'(e.ap));
         chk("set_err", int'(set_err), int'(e.err));
         chk("set_ready", int'(set_ready), int'(e.rdy));
         chk("digit_select", int'(digit_select), e.dig);
         chk("segment_data", int'(segment_data), e.seg);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int aps, seen, hh, mm;
      repeat (3) cyc();
      chk("rst_ready", int'(set_ready), 0);
      chk("rst_seg", int'(segment_data), 0);
      chk("rst_digit", int'(digit_select), 0);
      chk("rst_time", int'({hour, min, sec}), 0);
      reset = 0;
      idle(3);
      chk("t1_no_pulse", int'(sec_pulse), 0);
      idle(1);
      chk("t1_pulse", int'(sec_pulse), 1);
      chk("t1_sec", int'(sec), 1);
      idle(8);
      chk("t1_sec3", int'(sec), 3);
      load(23, 59, 59);
      idle(3);
      chk("t2_sec59", int'(sec), 59);
      idle(1);
      chk("t2_wrap", int'({hour, min, sec}), 0);
      mil_time = 0;
      #1;
      chk("t2_hour12", int'(hour), 12);
      chk("t2_am", int'(am_pm), 0);
      load(13, 5, 0);
      chk("t3_hour", int'(hour), 1);
      chk("t3_pm", int'(am_pm), 1);
      seen = 0;
      repeat (8) begin
         idle(1);
         if (digit_select == 3'd4) begin chk("t3_ones", int'(segment_data), 'h86); seen |= 1; end
         if (digit_select == 3'd5) begin chk("t3_tens", int'(segment_data), 'h00); seen |= 2; end
      end
      chk("t3_digits_seen", seen, 3);
      mil_time = 1;
      idle(1);
      hh = m_t;
      load(24, 10, 10);
      chk("t4_err", int'(set_err), 1);
      chk("t4_ready", int'(set_ready), 0);
      chk("t4_hour", int'(hour), hh / 3600);
      idle(1);
      chk("t4_err_clr", int'(set_err), 0);
      chk("t4_ready_back", int'(set_ready), 1);
      alarm_hour = 7; alarm_min = 0; alarm_en = 1;
      load(6, 59, 59);
      aps = 0;
      repeat (6) begin idle(1); aps += int'(alarm_pulse); end
      chk("t5_alarm_once", aps, 1);
      load(7, 0, 0);
      aps = int'(alarm_pulse);
      repeat (3) begin idle(1); aps += int'(alarm_pulse); end
      chk("t5_no_alarm_on_load", aps, 0);
      idle(2);
      set_hour = 1; set_min = 2; set_sec = 3; set_valid = 1; reset = 1;
      cyc();
      chk("t6_time", int'({hour, min, sec}), 0);
      chk("t6_ready", int'(set_ready), 0);
      chk("t6_seg", int'(segment_data), 0);
      reset = 0; set_valid = 0;
      idle(1);
      chk("t6_dropped", int'({hour, min, sec}), 0);
      for (int i = 0; i < 4000; i++) begin
         reset = $urandom_range(0, 999) == 0;
         if ($urandom_range(0, 49) == 0) mil_time = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) begin
            alarm_hour = 5'($urandom_range(0, 31));
            alarm_min = 6'($urandom_range(0, 63));
         end else if ($urandom_range(0, 49) == 0) begin
            mm = (m_t / 60 + 1) % 1440;
            alarm_hour = 5'(mm / 60);
            alarm_min = 6'(mm % 60);
         end
         alarm_en = $urandom_range(0, 9) != 0;
         set_valid = $urandom_range(0, 7) == 0;
         if ($urandom_range(0, 1) == 0) begin
            set_hour = 5'($urandom_range(0, 31));
            set_min = 6'($urandom_range(0, 63));
            set_sec = 6'($urandom_range(0, 63));
         end else begin
            set_hour = 5'($urandom_range(0, 1) ? 23 : $urandom_range(0, 23));
            set_min = 6'($urandom_range(58, 59));
            set_sec = 6'($urandom_range(55, 59));
         end
         cyc();
      end
      reset = 0;
      idle(2);
      @(negedge clk_1ms);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
